seg7_scan: RTL

Multiplexed 6-digit seven-segment display driver downstream of the binary-to-BCD converter. Captures a 5-digit packed BCD magnitude plus a sign flag on an update strobe. Refreshes the value frame-synchronously, so a frame never shows a mix of old and new digits. Scans the digits with leading-zero blanking, a fixed decimal point and inter-digit ghost blanking.

---
 rtl/seg7_scan.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Six-digit multiplexed seven-segment driver: 5 BCD digits plus a sign digit,
// frame-synchronous refresh, leading-zero blanking and inter-digit ghost blanking.
module seg7_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 16,
  parameter int DP_POS   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] dec,
  input  logic        neg,
  input  logic        upd,
  output logic [7:0]  seg,
  output logic [5:0]  sel
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [5:0] SEL_OFF   = 6'h3F;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          slot_end;
  logic [19:0]   hold_val;
  logic [19:0]   frame_val;
  logic          hold_neg;
  logic          frame_neg;
  logic [3:0]    digit;
  logic [2:0]    msd;
  logic          blank_digit;
  logic [7:0]    seg_d;
  logic [5:0]    sel_d;

  assign slot_end = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The frame copy only moves at the start of a frame, so one frame never mixes values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_val  <= '0;
      hold_neg  <= 1'b0;
      frame_val <= '0;
      frame_neg <= 1'b0;
    end else begin
      if (upd) begin
        hold_val <= dec;
        hold_neg <= neg;
      end
      if (slot_end && idx == 3'd5) begin
        frame_val <= hold_val;
        frame_neg <= hold_neg;
      end
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'h86;
    endcase
  endfunction

  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (frame_val[4*i +: 4] != 4'd0) msd = 3'(i);
    end
  end

  always_comb begin
    case (idx)
      3'd0:    digit = frame_val[3:0];
      3'd1:    digit = frame_val[7:4];
      3'd2:    digit = frame_val[11:8];
      3'd3:    digit = frame_val[15:12];
      3'd4:    digit = frame_val[19:16];
      default: digit = 4'd0;
    endcase
  end

  // Outputs are computed from cnt/idx and registered, so the pins never glitch.
  always_comb begin
    blank_digit = (idx > msd) && (idx > 3'(DP_POS));
    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    if (cnt >= CW'(BLANK)) begin
      sel_d = ~(6'd1 << idx);
      if (idx == 3'd5) begin
        seg_d = (frame_neg && frame_val != 20'd0) ? SEG_MINUS : SEG_OFF;
      end else if (!blank_digit) begin
        seg_d = glyph(digit);
        if (idx == 3'(DP_POS)) seg_d[7] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      sel <= SEL_OFF;
    end else begin
      seg <= seg_d;
      sel <= sel_d;
    end
  end

endmodule
